// File: rtl/rv_alu_arbiter.sv
// rv_alu_arbiter: shares one combinational integer ALU between two
// valid/ready requesters. Round-robin grant, one registered result slot,
// one operation per cycle.

// Combinational RV32-style integer ALU, op = {funct7[5], funct3}.
module rv_alu #(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_res
);

   logic [4:0] w_shamt;

   assign w_shamt = i_b[4:0];

   // Decode the op code and compute the result
   always_comb begin
      // NOTE: default assignment first so every path drives o_res and no latch is inferred.
      o_res = '0;
      case (i_op)
         4'b0000: o_res = i_a + i_b;
         4'b1000: o_res = i_a - i_b;
         4'b0100: o_res = i_a ^ i_b;
         4'b0110: o_res = i_a | i_b;
         4'b0111: o_res = i_a & i_b;
         4'b0001: o_res = i_a << w_shamt;
         4'b0101: o_res = i_a >> w_shamt;
         4'b1101: o_res = $unsigned($signed(i_a) >>> w_shamt);
         4'b0010: o_res = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         4'b0011: o_res = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
         default: o_res = '0;
      endcase
   end

endmodule

// Two-port arbiter in front of the shared ALU.
module rv_alu_arbiter #(
   parameter int BUS_W  = 32,
   parameter int DATA_W = BUS_W
) (
   input  logic              clk,
   input  logic              rst_n,
   // port 0: pipeline execute stage
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [3:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_data,
   // port 1: auxiliary address / key-schedule unit
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [3:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_data
);

   logic              r_res_valid;
   logic              r_res_owner;
   logic [DATA_W-1:0] r_res_data;
   logic              r_last_grant;

   logic              w_owner_ready;
   logic              w_can_accept;
   logic              w_grant;
   logic              w_accept;
   logic [3:0]        w_op;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_alu_res;

   // Only the current owner's consumer can free the result slot, so the
   // other port's rsp_ready never reaches the request-ready path.
   assign w_owner_ready = r_res_owner ? rsp1_ready : rsp0_ready;
   assign w_can_accept  = !r_res_valid || w_owner_ready;

   // Round-robin: a lone requester wins; on contention the port not
   // granted last time wins.
   assign w_grant    = (req0_valid && req1_valid) ? !r_last_grant : req1_valid;
   assign req0_ready = !w_grant && req0_valid && w_can_accept;
   assign req1_ready =  w_grant && req1_valid && w_can_accept;
   assign w_accept   = req0_ready || req1_ready;

   assign w_op = w_grant ? req1_op : req0_op;
   assign w_a  = w_grant ? req1_a  : req0_a;
   assign w_b  = w_grant ? req1_b  : req0_b;

   rv_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .i_op  (w_op),
      .i_a   (w_a),
      .i_b   (w_b),
      .o_res (w_alu_res)
   );

   // Result slot and arbitration history; an accept overwrites a result
   // that is draining in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid  <= 1'b0;
         r_res_owner  <= 1'b0;
         r_res_data   <= '0;
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_res_valid  <= 1'b1;
         r_res_owner  <= w_grant;
         r_res_data   <= w_alu_res;
         r_last_grant <= w_grant;
      end else if (r_res_valid && w_owner_ready) begin
         r_res_valid  <= 1'b0;
      end
   end

   assign rsp0_valid = r_res_valid && !r_res_owner;
   assign rsp1_valid = r_res_valid &&  r_res_owner;
   assign rsp0_data  = rsp0_valid ? r_res_data : '0;
   assign rsp1_data  = rsp1_valid ? r_res_data : '0;

endmodule

// File: tb/tb_rv_alu_arbiter.sv
// Self-checking bench for rv_alu_arbiter: directed scenarios followed by a
// randomized soak against a scoreboard reference model.
module tb_rv_alu_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic [3:0]   req0_op;
   logic [W-1:0] req0_a, req0_b, rsp0_data;
   logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [3:0]   req1_op;
   logic [W-1:0] req1_a, req1_b, rsp1_data;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic         port;
      logic [W-1:0] data;
   } sb_t;

   sb_t  sb[$];
   logic m_last;

   rv_alu_arbiter #(.DATA_W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_data  (rsp0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_data  (rsp1_data)
   );

   always #5 clk = ~clk;

   // Reference ALU written from the op table with plain arithmetic.
   function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W-1:0] sign_flip;
      int           sh;
      sign_flip = 32'h8000_0000;
      sh        = int'(b % 32);
      case (op)
         4'b0000: return a + b;
         4'b1000: return a + (~b) + 1;
         4'b0100: return a ^ b;
         4'b0110: return a | b;
         4'b0111: return a & b;
         4'b0001: return a * (32'd1 << sh);
         4'b0101: return a / (32'd1 << sh);
         4'b1101: return a[W-1] ? ~((~a) >> sh) : (a >> sh);
         4'b0010: return ((a ^ sign_flip) < (b ^ sign_flip)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_op = 4'h0; req0_a = '0; req0_b = '0; rsp0_ready = 1'b1;
      req1_valid = 1'b0; req1_op = 4'h0; req1_a = '0; req1_b = '0; rsp1_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   // Issue one op on port 0 alone and check its result a cycle later.
   task automatic issue0(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; rsp0_ready = 1'b1;
      #1;
      check({tag, "_ready"}, 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      #1;
      check({tag, "_data"}, rsp0_data, exp);
   endtask

   initial begin
      logic         acc0, acc1, occ, own, drain, can, g, e_r0, e_r1;
      int           skip0, skip1;
      logic [W-1:0] e_d0, e_d1;

      // ---------------- reset state
      idle_inputs();
      step();
      check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      check("rst_rsp0_data", rsp0_data, 32'd0);
      check("rst_rsp1_data", rsp1_data, 32'd0);
      check("rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      rst_n = 1'b1;
      step();

      // ---------------- port 0 alone: ADD 5 + 3
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd5; req0_b = 32'd3;
      #1;
      check("add_req0_ready", 32'(req0_ready), 32'd1);
      check("add_req1_ready", 32'(req1_ready), 32'd0);
      step();
      req0_valid = 1'b0;
      #1;
      check("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("add_rsp0_data", rsp0_data, 32'h0000_0008);
      check("add_rsp1_valid", 32'(rsp1_valid), 32'd0);
      step();
      check("add_drained", 32'(rsp0_valid), 32'd0);

      // ---------------- contention after reset: p0 then p1
      do_reset();
      req0_valid = 1'b1; req0_op = 4'b1000; req0_a = 32'h0;         req0_b = 32'h1;
      req1_valid = 1'b1; req1_op = 4'b1101; req1_a = 32'h8000_0000; req1_b = 32'd4;
      #1;
      check("cont_ready0_first", {30'd0, req1_ready, req0_ready}, 32'b01);
      step();
      req0_valid = 1'b0;
      #1;
      check("cont_rsp0_data", rsp0_data, 32'hFFFF_FFFF);
      check("cont_ready1_second", {30'd0, req1_ready, req0_ready}, 32'b10);
      step();
      req1_valid = 1'b0;
      #1;
      check("cont_rsp1_data", rsp1_data, 32'hF800_0000);
      check("cont_rsp0_gone", 32'(rsp0_valid), 32'd0);
      step();

      // ---------------- backpressure on port 1
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1;
      #1;
      check("bp_req1_ready", 32'(req1_ready), 32'd1);
      step();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd10; req0_b = 32'd20;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp_hold_valid_%0d", i), 32'(rsp1_valid), 32'd1);
         check($sformatf("bp_hold_data_%0d", i), rsp1_data, 32'd1);
         check($sformatf("bp_req0_blocked_%0d", i), 32'(req0_ready), 32'd0);
         step();
      end
      rsp1_ready = 1'b1;
      #1;
      check("bp_release_data", rsp1_data, 32'd1);
      check("bp_req0_accept", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      #1;
      check("bp_rsp0_data", rsp0_data, 32'd30);
      check("bp_rsp1_done", 32'(rsp1_valid), 32'd0);
      step();

      // ---------------- op coverage on port 0
      issue0("sltu", 4'b0011, 32'hFFFF_FFFF, 32'h1,         32'h0);
      issue0("sll",  4'b0001, 32'h1,         32'h21,        32'h2);
      issue0("ill",  4'b1111, 32'h1234_5678, 32'h1,         32'h0);
      issue0("xor",  4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
      issue0("or",   4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
      issue0("and",  4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
      issue0("srl",  4'b0101, 32'h8000_0000, 32'd4,         32'h0800_0000);
      issue0("addw", 4'b0000, 32'hFFFF_FFFF, 32'h2,         32'h1);
      step();

      // ---------------- reset mid-operation
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
      step();
      req0_valid = 1'b0;
      #1;
      check("mid_rsp0_before", rsp0_data, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_async_valid", 32'(rsp0_valid), 32'd0);
      check("mid_async_data", rsp0_data, 32'd0);
      step();
      rst_n = 1'b1;
      rsp0_ready = 1'b1;
      step();
      check("mid_no_stale", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("mid_cont_p0_first", {30'd0, req1_ready, req0_ready}, 32'b01);
      step();
      idle_inputs();

      // ---------------- random soak against the scoreboard
      do_reset();
      sb.delete();
      m_last = 1'b1;
      acc0 = 1'b0; acc1 = 1'b0; skip0 = 0; skip1 = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (!req0_valid || acc0) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_op    = 4'($urandom_range(0, 15));
            req0_a     = $urandom;
            req0_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         end
         if (!req1_valid || acc1) begin
            req1_valid = 1'($urandom_range(0, 1));
            req1_op    = 4'($urandom_range(0, 15));
            req1_a     = $urandom;
            req1_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         end
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
         #1;

         // The result slot is a queue of at most one pending response.
         occ   = (sb.size() != 0);
         own   = occ ? sb[0].port : 1'b0;
         drain = occ && (own ? rsp1_ready : rsp0_ready);
         can   = !occ || drain;
         g     = (req0_valid && req1_valid) ? !m_last : req1_valid;
         e_r0  = can && req0_valid && !g;
         e_r1  = can && req1_valid && g;
         e_d0  = (occ && !own) ? sb[0].data : '0;
         e_d1  = (occ &&  own) ? sb[0].data : '0;

         check($sformatf("soak%0d_ready0", cyc), 32'(req0_ready), 32'(e_r0));
         check($sformatf("soak%0d_ready1", cyc), 32'(req1_ready), 32'(e_r1));
         check($sformatf("soak%0d_rsp_valid", cyc), {30'd0, rsp1_valid, rsp0_valid},
               {30'd0, occ && own, occ && !own});
         check($sformatf("soak%0d_rsp0_data", cyc), rsp0_data, e_d0);
         check($sformatf("soak%0d_rsp1_data", cyc), rsp1_data, e_d1);
         check($sformatf("soak%0d_one_accept", cyc), 32'(req0_ready && req1_ready), 32'd0);

         if (req0_ready) skip0 = 0;
         else if (req0_valid && req1_ready) skip0++;
         if (req1_ready) skip1 = 0;
         else if (req1_valid && req0_ready) skip1++;
         check($sformatf("soak%0d_no_starve", cyc), {30'd0, skip1 <= 1, skip0 <= 1}, 32'b11);

         acc0 = e_r0;
         acc1 = e_r1;
         if (drain) void'(sb.pop_front());
         if (acc0 || acc1) begin
            sb.push_back('{g, g ? alu_ref(req1_op, req1_a, req1_b)
                                : alu_ref(req0_op, req0_a, req0_b)});
            m_last = g;
         end
         step();
      end

      idle_inputs();
      step();
      step();
      check("final_idle", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
